// File: rtl/hazard_ctrl.sv
// Purpose : pipeline hazard/stall sequencer for the 5-stage core (load-use, redirect flush, dmem wait).
// Latency : stall/flush/bubble outputs are combinational (zero cycles); mem_err and counters are registered.
// Backpres: an unacknowledged data-memory access freezes every stage until dmem_ack or reset.
//
// Optional feature macro: HAZARD_PERF_EN (performance counters stall_cycles / flush_count).
//
// Ports:
//   clk, rstn                      core clock, synchronous active-low reset
//   id_rs1, id_rs2, id_use_rs1/2   ID-stage source registers and their read enables
//   ex_rd, ex_mem_read             EX-stage destination and "is a load" flag
//   ex_redirect                    EX resolved a taken branch / jal / jalr
//   mem_req, dmem_ack              MEM-stage access request and memory completion
//   pc_stall .. memwb_bubble       per-register hold / clear controls
//   mem_err                        sticky memory-timeout error
//   stall_cycles, flush_count      performance counters (tied to 0 without HAZARD_PERF_EN)

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ack,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Wait counter only needs to reach MEM_TIMEOUT; keep at least one bit.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Value the counter holds on the cycle whose miss would make it reach MEM_TIMEOUT.
  localparam logic [WAIT_W-1:0] TIMEOUT_M1 = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MEMWAIT = 2'd1,
    S_ERR     = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic freeze;
  logic load_use;
  logic timeout_hit;

  // ---------------------------------------------------------------------------
  // Hazard conditions
  // ---------------------------------------------------------------------------
  always_comb begin
    freeze = ((state == S_RUN)     && mem_req && !dmem_ack) ||
             ((state == S_MEMWAIT) && !dmem_ack)            ||
             (state == S_ERR);
  end

  // x0 is never a real dependency, so a load targeting x0 never stalls.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // In S_MEMWAIT the counter already counts the cycles waited so far; a further
  // miss this cycle is the one that reaches the limit.
  always_comb begin
    timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_M1);
  end

  // ---------------------------------------------------------------------------
  // Stall / flush controls. Priority: freeze > redirect > load-use.
  // A redirect beats load-use because the ID instruction is on the wrong path
  // and is being discarded anyway. During freeze the EX instruction is held,
  // so a pending redirect is simply re-presented once the freeze drops.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    if (rstn) begin
      if (freeze) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
      end else if (ex_redirect) begin
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, inject one bubble into EX; next cycle the load
        // sits in MEM and forwarding covers the dependency.
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_flush   = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-wait FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (mem_req && !dmem_ack) begin
            wait_cnt <= WAIT_W'(1);
            if (MEM_TIMEOUT == 1) begin
              // The first missed cycle already reaches a limit of one.
              state   <= S_ERR;
              mem_err <= 1'b1;
            end else begin
              state   <= S_MEMWAIT;
            end
          end
        end

        S_MEMWAIT: begin
          if (dmem_ack) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state    <= S_ERR;
            mem_err  <= 1'b1;
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end else if (wait_cnt != '1) begin
            // Saturate so a disabled timeout never wraps back to zero.
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        S_ERR: begin
          // Terminal until reset; late acknowledges are ignored.
          mem_err <= 1'b1;
        end

        default: begin
          state    <= S_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_stall) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (ifid_flush) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
// Latency : control outputs checked in the same cycle their inputs are applied.
// Backpres: memory waits are driven by holding dmem_ack low for fixed cycle counts.

module tb_hazard_ctrl;

  localparam int CNT_W = 32;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble
  localparam logic [6:0] C_IDLE    = 7'b0000000;
  localparam logic [6:0] C_FREEZE  = 7'b1101011;
  localparam logic [6:0] C_LOADUSE = 7'b1100100;
  localparam logic [6:0] C_REDIR   = 7'b0010100;

  logic             clk = 1'b0;
  logic             rstn;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, dmem_ack;
  logic             pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic             exmem_stall, memwb_bubble, mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [6:0]       ctl;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble};

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .dmem_ack     (dmem_ack),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .idex_stall   (idex_stall),
    .idex_flush   (idex_flush),
    .exmem_stall  (exmem_stall),
    .memwb_bubble (memwb_bubble),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic mr, input logic redir,
                        input logic req, input logic ack);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_redirect = redir; mem_req = req; dmem_ack = ack;
  endtask

  task automatic set_idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    set_idle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL rst_forced0: got %b want %b", ctl, C_IDLE); end
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL rst_forced1: got %b want %b", ctl, C_IDLE); end
    tick();
    rstn = 1'b1;
    set_idle();
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL rst_idle: got %b want %b", ctl, C_IDLE); end
    checks++;
    if (mem_err !== 1'b0) begin fails++; $display("FAIL rst_mem_err: got %b want 0", mem_err); end
    checks++;
    if (stall_cycles !== '0) begin fails++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cycles); end
    checks++;
    if (flush_count !== '0) begin fails++; $display("FAIL rst_flush_cnt: got %0d want 0", flush_count); end
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    set_in(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== C_LOADUSE) begin fails++; $display("FAIL lu_rs2: got %b want %b", ctl, C_LOADUSE); end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL lu_release: got %b want %b", ctl, C_IDLE); end
    tick();
    set_in(5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== C_LOADUSE) begin fails++; $display("FAIL lu_rs1: got %b want %b", ctl, C_LOADUSE); end
    tick();
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL lu_x0: got %b want %b", ctl, C_IDLE); end
    tick();
    set_in(5'd2, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL lu_rs2_unused: got %b want %b", ctl, C_IDLE); end
    tick();
    set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL lu_not_load: got %b want %b", ctl, C_IDLE); end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if (stall_cycles !== (PERF ? 32'd2 : 32'd0)) begin
      fails++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cycles, PERF ? 2 : 0);
    end
    tick();
  endtask

  task automatic test_redirect();
    apply_reset();
    set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== C_REDIR) begin fails++; $display("FAIL redir_hazard: got %b want %b", ctl, C_REDIR); end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL redir_release: got %b want %b", ctl, C_IDLE); end
    checks++;
    if (flush_count !== (PERF ? 32'd1 : 32'd0)) begin
      fails++; $display("FAIL redir_flush_cnt: got %0d want %0d", flush_count, PERF ? 1 : 0);
    end
    checks++;
    if (stall_cycles !== '0) begin fails++; $display("FAIL redir_stall_cnt: got %0d want 0", stall_cycles); end
    tick();
  endtask

  task automatic test_mem_wait();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      // Load-use inputs held active to show detection is suppressed during freeze.
      set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl !== C_FREEZE) begin fails++; $display("FAIL memwait_freeze[%0d]: got %b want %b", i, ctl, C_FREEZE); end
      tick();
    end
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL memwait_ack: got %b want %b", ctl, C_IDLE); end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL memwait_run: got %b want %b", ctl, C_IDLE); end
    checks++;
    if (mem_err !== 1'b0) begin fails++; $display("FAIL memwait_err: got %b want 0", mem_err); end
    checks++;
    if (stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin
      fails++; $display("FAIL memwait_stall_cnt: got %0d want %0d", stall_cycles, PERF ? 3 : 0);
    end
    tick();
  endtask

  task automatic test_redirect_during_wait();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl !== C_FREEZE) begin fails++; $display("FAIL rdw_freeze[%0d]: got %b want %b", i, ctl, C_FREEZE); end
      tick();
    end
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== C_REDIR) begin fails++; $display("FAIL rdw_ack_flush: got %b want %b", ctl, C_REDIR); end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if (flush_count !== (PERF ? 32'd1 : 32'd0)) begin
      fails++; $display("FAIL rdw_flush_cnt: got %0d want %0d", flush_count, PERF ? 1 : 0);
    end
    checks++;
    if (stall_cycles !== (PERF ? 32'd2 : 32'd0)) begin
      fails++; $display("FAIL rdw_stall_cnt: got %0d want %0d", stall_cycles, PERF ? 2 : 0);
    end
    tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      checks++;
      if (ctl !== C_FREEZE) begin fails++; $display("FAIL to_freeze[%0d]: got %b want %b", i, ctl, C_FREEZE); end
      checks++;
      if (mem_err !== 1'b0) begin fails++; $display("FAIL to_err_early[%0d]: got %b want 0", i, mem_err); end
      tick();
    end
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b1) begin fails++; $display("FAIL to_err_set: got %b want 1", mem_err); end
    checks++;
    if (ctl !== C_FREEZE) begin fails++; $display("FAIL to_late_ack: got %b want %b", ctl, C_FREEZE); end
    tick();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== C_FREEZE) begin fails++; $display("FAIL to_ack_noreq: got %b want %b", ctl, C_FREEZE); end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if (ctl !== C_FREEZE) begin fails++; $display("FAIL to_idle_frozen: got %b want %b", ctl, C_FREEZE); end
    checks++;
    if (mem_err !== 1'b1) begin fails++; $display("FAIL to_err_sticky: got %b want 1", mem_err); end
    checks++;
    if (stall_cycles !== (PERF ? 32'd6 : 32'd0)) begin
      fails++; $display("FAIL to_stall_cnt: got %0d want %0d", stall_cycles, PERF ? 6 : 0);
    end
    tick();
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL to_rst_forced: got %b want %b", ctl, C_IDLE); end
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b0) begin fails++; $display("FAIL to_rst_err: got %b want 0", mem_err); end
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL to_rst_run: got %b want %b", ctl, C_IDLE); end
    checks++;
    if (stall_cycles !== '0) begin fails++; $display("FAIL to_rst_stall_cnt: got %0d want 0", stall_cycles); end
    tick();
  endtask

  task automatic test_zero_wait();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (ctl !== C_IDLE) begin fails++; $display("FAIL zw_nostall[%0d]: got %b want %b", i, ctl, C_IDLE); end
      tick();
    end
    set_idle();
    @(negedge clk);
    checks++;
    if (ctl !== C_IDLE) begin fails++; $display("FAIL zw_run: got %b want %b", ctl, C_IDLE); end
    checks++;
    if (stall_cycles !== '0) begin fails++; $display("FAIL zw_stall_cnt: got %0d want 0", stall_cycles); end
    tick();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_in(5'd9, 5'd1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== C_LOADUSE) begin fails++; $display("FAIL b2b_lu: got %b want %b", ctl, C_LOADUSE); end
    tick();
    set_in(5'd9, 5'd1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== C_REDIR) begin fails++; $display("FAIL b2b_redir: got %b want %b", ctl, C_REDIR); end
    tick();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== C_FREEZE) begin fails++; $display("FAIL b2b_freeze: got %b want %b", ctl, C_FREEZE); end
    tick();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (ctl !== C_REDIR) begin fails++; $display("FAIL b2b_ack_redir: got %b want %b", ctl, C_REDIR); end
    tick();
    set_in(5'd4, 5'd12, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ctl !== C_LOADUSE) begin fails++; $display("FAIL b2b_lu2: got %b want %b", ctl, C_LOADUSE); end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if (stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin
      fails++; $display("FAIL b2b_stall_cnt: got %0d want %0d", stall_cycles, PERF ? 3 : 0);
    end
    checks++;
    if (flush_count !== (PERF ? 32'd2 : 32'd0)) begin
      fails++; $display("FAIL b2b_flush_cnt: got %0d want %0d", flush_count, PERF ? 2 : 0);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_redirect_during_wait();
    test_timeout();
    test_zero_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
